// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the key-schedule blocks.
// Pure constants and functions; no state, no latency.
// No flow control of its own.
package aes_pkg;

  localparam int WORD_LEN   = 32;
  localparam int KEY_LEN    = 128;
  localparam int NUM_ROUNDS = 10;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_SUB  = 2'd2,
    ST_XOR  = 2'd3
  } state_t;

  // Forward AES S-box, index 0 first
  localparam logic [7:0] SBOX_TBL [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[b];
  endfunction

  // Round constant used when round key r was derived from r-1
  function automatic logic [31:0] rcon(input logic [3:0] round);
    logic [7:0] c;
    case (round)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h000000};
  endfunction

endpackage

// File: rtl/key_sub_word.sv
// Registered SubWord: forward S-box applied to each of the four bytes.
// Latency 1 cycle from valid_in to valid_out.
// No backpressure; output word holds its value while valid_in is low.
module key_sub_word
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  output logic        valid_out,
  output logic [31:0] data_out
);

  // Capture substituted word on valid_in; hold otherwise
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        data_out <= {sbox(data_in[31:24]), sbox(data_in[23:16]),
                     sbox(data_in[15:8]),  sbox(data_in[7:0])};
      end
    end
  end

endmodule

// File: rtl/inv_key_sched.sv
// AES-128 inverse key scheduler: loads round-10 key, emits rounds 10..0.
// Latency: first key the cycle after start; then one key every 3 cycles.
// Holds key_out/key_round stable while key_valid & !key_ready; start ignored unless idle.
module inv_key_sched #(
  parameter int KEY_LEN    = aes_pkg::KEY_LEN,
  parameter int WORD_LEN   = aes_pkg::WORD_LEN,
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [KEY_LEN-1:0] key_in,
  output logic               start_ready,
  output logic [KEY_LEN-1:0] key_out,
  output logic [3:0]         key_round,
  output logic               key_valid,
  input  logic               key_ready,
  output logic               done
);
  import aes_pkg::*;

  state_t state, next_state;

  logic [KEY_LEN-1:0]  key_reg;
  logic [3:0]          round_cnt;
  logic [WORD_LEN-1:0] w0, w1, w2, w3;
  logic [WORD_LEN-1:0] p1_q, p2_q, p3_q;
  logic [WORD_LEN-1:0] p3_now, rot_p3, p0;
  logic [WORD_LEN-1:0] sub_word;
  logic                sub_start, sub_valid;
  logic                accept, load;

  // w0 is the most significant word of a round key
  assign w0 = key_reg[KEY_LEN-1            -: WORD_LEN];
  assign w1 = key_reg[KEY_LEN-1-WORD_LEN   -: WORD_LEN];
  assign w2 = key_reg[KEY_LEN-1-2*WORD_LEN -: WORD_LEN];
  assign w3 = key_reg[WORD_LEN-1:0];

  // Previous-round w3 is w3^w2; its rotation feeds the S-box stage
  assign p3_now = w3 ^ w2;
  assign rot_p3 = {p3_now[WORD_LEN-9:0], p3_now[WORD_LEN-1 -: 8]};

  // w0 of the previous round; round_cnt still names the current key here
  assign p0 = w0 ^ sub_word ^ rcon(round_cnt);

  key_sub_word u_sub_word (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (sub_start),
    .data_in   (rot_p3),
    .valid_out (sub_valid),
    .data_out  (sub_word)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore outputs; key_out is zero whenever no key is offered
  always_comb begin
    next_state  = state;
    start_ready = 1'b0;
    key_valid   = 1'b0;
    key_out     = '0;
    key_round   = 4'd0;
    accept      = 1'b0;
    load        = 1'b0;
    sub_start   = 1'b0;
    case (state)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start) begin
          load       = 1'b1;
          next_state = ST_EMIT;
        end
      end
      ST_EMIT: begin
        key_valid = 1'b1;
        key_out   = key_reg;
        key_round = round_cnt;
        if (key_ready) begin
          accept     = 1'b1;
          next_state = (round_cnt == 4'd0) ? ST_IDLE : ST_SUB;
        end
      end
      ST_SUB: begin
        sub_start  = 1'b1;
        next_state = ST_XOR;
      end
      ST_XOR: begin
        if (sub_valid) begin
          next_state = ST_EMIT;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Key register, round counter, partial words and done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_reg   <= '0;
      round_cnt <= 4'd0;
      p1_q      <= '0;
      p2_q      <= '0;
      p3_q      <= '0;
      done      <= 1'b0;
    end else begin
      done <= accept && (round_cnt == 4'd0);
      if (load) begin
        key_reg   <= key_in;
        round_cnt <= 4'(NUM_ROUNDS);
      end
      if (state == ST_SUB) begin
        p3_q <= p3_now;
        p2_q <= w2 ^ w1;
        p1_q <= w1 ^ w0;
      end
      if (state == ST_XOR && sub_valid) begin
        key_reg   <= {p0, p1_q, p2_q, p3_q};
        round_cnt <= round_cnt - 4'd1;
      end
    end
  end

endmodule
